// File: rtl/alu_pkg.sv
// Shared encodings for the EX-stage ALU control: ALU control codes, op classes,
// funct constants, mult/div op codes and the R-type funct decoder.
package alu_pkg;

  localparam logic [3:0] CTRL_AND  = 4'b0000;
  localparam logic [3:0] CTRL_OR   = 4'b0001;
  localparam logic [3:0] CTRL_ADD  = 4'b0010;
  localparam logic [3:0] CTRL_XOR  = 4'b0011;
  localparam logic [3:0] CTRL_SLTU = 4'b0101;
  localparam logic [3:0] CTRL_SUB  = 4'b0110;
  localparam logic [3:0] CTRL_SLT  = 4'b0111;
  localparam logic [3:0] CTRL_NOR  = 4'b1100;

  localparam logic [2:0] OP_ADD   = 3'd0;
  localparam logic [2:0] OP_SUB   = 3'd1;
  localparam logic [2:0] OP_RTYPE = 3'd2;
  localparam logic [2:0] OP_AND   = 3'd3;
  localparam logic [2:0] OP_OR    = 3'd4;
  localparam logic [2:0] OP_SLT   = 3'd5;
  localparam logic [2:0] OP_SLTU  = 3'd6;

  localparam logic [5:0] F_ADD  = 6'b100000;
  localparam logic [5:0] F_ADDU = 6'b100001;
  localparam logic [5:0] F_SUB  = 6'b100010;
  localparam logic [5:0] F_SUBU = 6'b100011;
  localparam logic [5:0] F_AND  = 6'b100100;
  localparam logic [5:0] F_OR   = 6'b100101;
  localparam logic [5:0] F_XOR  = 6'b100110;
  localparam logic [5:0] F_NOR  = 6'b100111;
  localparam logic [5:0] F_SLT  = 6'b101010;
  localparam logic [5:0] F_SLTU = 6'b101011;
  localparam logic [5:0] F_MFHI = 6'b010000;
  localparam logic [5:0] F_MFLO = 6'b010010;
  localparam logic [3:0] F_MD_PREFIX = 4'b0110;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } md_state_e;

  typedef struct packed {
    logic [3:0] ctrl;
    logic       illegal;
    logic       is_md;
    logic       is_hilo;
  } dec_t;

  function automatic dec_t decode_rtype(input logic [5:0] f);
    dec_t d;
    d = '{ctrl: CTRL_ADD, illegal: 1'b0, is_md: 1'b0, is_hilo: 1'b0};
    case (f)
      F_ADD, F_ADDU: d.ctrl = CTRL_ADD;
      F_SUB, F_SUBU: d.ctrl = CTRL_SUB;
      F_AND:         d.ctrl = CTRL_AND;
      F_OR:          d.ctrl = CTRL_OR;
      F_XOR:         d.ctrl = CTRL_XOR;
      F_NOR:         d.ctrl = CTRL_NOR;
      F_SLT:         d.ctrl = CTRL_SLT;
      F_SLTU:        d.ctrl = CTRL_SLTU;
      F_MFHI, F_MFLO: d.is_hilo = 1'b1;
      default: begin
        // mult/multu/div/divu share the 0110xx prefix; low bits are the md_op code
        if (f[5:2] == F_MD_PREFIX) d.is_md = 1'b1;
        else                       d.illegal = 1'b1;
      end
    endcase
    return d;
  endfunction

endpackage

// File: rtl/alu_ctrl_md_md_seq.sv
// Mult/div sequencer: IDLE/BUSY/DONE FSM with a latency down-counter, issuing
// the datapath start pulse and the one-cycle HI/LO write enable.
module md_seq
  import alu_pkg::*;
#(
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 32,
  parameter int CNT_W   = 6
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   i_start,
  input  md_op_e i_op,
  output logic   o_blocking,
  output logic   o_md_start,
  output md_op_e o_md_op,
  output logic   o_md_busy,
  output logic   o_hilo_we
);

  md_state_e        r_state;
  md_state_e        w_next_state;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_next_count;
  logic [CNT_W-1:0] w_load;
  logic             r_md_start;
  md_op_e           r_md_op;

  assign w_load = (i_op inside {MD_DIV, MD_DIVU}) ? CNT_W'(DIV_LAT - 1) : CNT_W'(MUL_LAT - 1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_count    <= '0;
      r_md_start <= 1'b0;
      r_md_op    <= MD_MULT;
    end else begin
      r_state    <= w_next_state;
      r_count    <= w_next_count;
      r_md_start <= i_start && (r_state != ST_BUSY);
      if (i_start && (r_state != ST_BUSY)) r_md_op <= i_op;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_next_count = r_count;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (i_start) begin
          w_next_state = ST_BUSY;
          w_next_count = w_load;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_BUSY: begin
        // DONE is entered as the count reaches zero; a zero load (latency 1) leaves at once
        if (r_count <= CNT_W'(1)) begin
          w_next_state = ST_DONE;
          w_next_count = '0;
        end else begin
          w_next_count = r_count - CNT_W'(1);
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    o_blocking = (r_state == ST_BUSY);
    o_md_busy  = (r_state != ST_IDLE);
    o_hilo_we  = (r_state == ST_DONE);
    o_md_start = r_md_start;
    o_md_op    = r_md_op;
  end

endmodule

// File: rtl/alu_ctrl_md.sv
// EX-stage ALU control: registered funct/op-class decode plus a mult/div
// sequencer that stalls dependent instructions while the unit is busy.
module alu_ctrl_md
  import alu_pkg::*;
#(
  parameter int ALUOP_W = 3,
  parameter int CTRL_W  = 4,
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 32,
  parameter int CNT_W   = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [ALUOP_W-1:0] alu_op,
  input  logic [5:0]         func,
  input  logic               flush,
  output logic               stall,
  output logic               out_valid,
  output logic [CTRL_W-1:0]  alu_ctrl,
  output logic               illegal,
  output logic               md_start,
  output logic [1:0]         md_op,
  output logic               md_busy,
  output logic               hilo_we
);

  function automatic dec_t decode(input logic [ALUOP_W-1:0] op, input logic [5:0] f);
    dec_t d;
    d = '{ctrl: CTRL_ADD, illegal: 1'b0, is_md: 1'b0, is_hilo: 1'b0};
    case (op)
      ALUOP_W'(OP_ADD):   d.ctrl = CTRL_ADD;
      ALUOP_W'(OP_SUB):   d.ctrl = CTRL_SUB;
      ALUOP_W'(OP_RTYPE): d = decode_rtype(f);
      ALUOP_W'(OP_AND):   d.ctrl = CTRL_AND;
      ALUOP_W'(OP_OR):    d.ctrl = CTRL_OR;
      ALUOP_W'(OP_SLT):   d.ctrl = CTRL_SLT;
      ALUOP_W'(OP_SLTU):  d.ctrl = CTRL_SLTU;
      default:            d.illegal = 1'b1;
    endcase
    return d;
  endfunction

  dec_t              w_dec;
  logic              w_live;
  logic              w_accept;
  logic              w_blocking;
  md_op_e            w_md_op;
  logic              r_out_valid;
  logic [CTRL_W-1:0] r_alu_ctrl;
  logic              r_illegal;

  // NOTE: combinational blocks assign every output unconditionally so no latch is inferred.
  always_comb begin
    w_dec    = decode(alu_op, func);
    w_live   = in_valid && !flush;
    stall    = w_live && w_blocking && (w_dec.is_md || w_dec.is_hilo);
    w_accept = w_live && !stall;
    w_md_op  = md_op_e'(func[1:0]);
  end

  // NOTE: state uses non-blocking assignments so all registers update from pre-edge values.
  // NOTE: only control registers exist here; each has a defined reset value.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_alu_ctrl  <= CTRL_W'(CTRL_ADD);
      r_illegal   <= 1'b0;
    end else begin
      r_out_valid <= w_accept;
      if (w_accept) begin
        r_alu_ctrl <= CTRL_W'(w_dec.ctrl);
        r_illegal  <= w_dec.illegal;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign alu_ctrl  = r_alu_ctrl;
  assign illegal   = r_illegal;

  md_seq #(
    .MUL_LAT(MUL_LAT),
    .DIV_LAT(DIV_LAT),
    .CNT_W  (CNT_W)
  ) u_md_seq (
    .clk       (clk),
    .rst       (rst),
    .i_start   (w_accept && w_dec.is_md),
    .i_op      (w_md_op),
    .o_blocking(w_blocking),
    .o_md_start(md_start),
    .o_md_op   (md_op),
    .o_md_busy (md_busy),
    .o_hilo_we (hilo_we)
  );

endmodule

// File: tb/tb_alu_ctrl_md.sv
// Self-checking bench for alu_ctrl_md: directed cases with literal expectations
// plus randomized traffic compared every cycle against a timeline-based model.
module tb_alu_ctrl_md;

  localparam int ALUOP_W = 3;
  localparam int CTRL_W  = 4;
  localparam int MUL_LAT = 4;
  localparam int DIV_LAT = 32;
  localparam int CNT_W   = 6;

  logic              clk = 1'b0;
  logic              rst, in_valid, flush;
  logic [ALUOP_W-1:0] alu_op;
  logic [5:0]        func;
  logic              stall, out_valid, illegal, md_start, md_busy, hilo_we;
  logic [CTRL_W-1:0] alu_ctrl;
  logic [1:0]        md_op;

  alu_ctrl_md #(
    .ALUOP_W(ALUOP_W), .CTRL_W(CTRL_W), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .alu_op(alu_op), .func(func), .flush(flush),
    .stall(stall), .out_valid(out_valid), .alu_ctrl(alu_ctrl), .illegal(illegal),
    .md_start(md_start), .md_op(md_op), .md_busy(md_busy), .hilo_we(hilo_we)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference decode straight from the encoding tables.
  function automatic void ref_decode(input logic [2:0] op, input logic [5:0] f,
                                     output logic [3:0] c, output logic ill,
                                     output logic md, output logic hl);
    c = 4'b0010; ill = 1'b0; md = 1'b0; hl = 1'b0;
    case (op)
      3'd0: c = 4'b0010;
      3'd1: c = 4'b0110;
      3'd3: c = 4'b0000;
      3'd4: c = 4'b0001;
      3'd5: c = 4'b0111;
      3'd6: c = 4'b0101;
      3'd2: begin
        case (f)
          6'b100000, 6'b100001: c = 4'b0010;
          6'b100010, 6'b100011: c = 4'b0110;
          6'b100100: c = 4'b0000;
          6'b100101: c = 4'b0001;
          6'b100110: c = 4'b0011;
          6'b100111: c = 4'b1100;
          6'b101010: c = 4'b0111;
          6'b101011: c = 4'b0101;
          6'b011000, 6'b011001, 6'b011010, 6'b011011: md = 1'b1;
          6'b010000, 6'b010010: hl = 1'b1;
          default: ill = 1'b1;
        endcase
      end
      default: ill = 1'b1;
    endcase
  endfunction

  // Model: a mult/div accepted in cycle t starts at t+1 and writes HI/LO in cycle t+LAT
  // (t+2 for a one-cycle latency); it is stalling-busy before that cycle.
  int         t = 0;
  bit         m_ready = 1'b0;
  bit         m_active = 1'b0;
  int         m_done = 0;
  logic [1:0] m_op = 2'b00;
  logic       e_ov = 1'b0, e_ill = 1'b0, e_start = 1'b0;
  logic [3:0] e_ctrl = 4'b0010;
  int         n_start = 0, n_hilo = 0;

  always @(negedge clk) begin : compare
    logic [3:0] c;
    logic ill, md, hl, in_busy, in_done, e_stall, acc;
    int lat;
    in_busy = m_active && (t < m_done);
    in_done = m_active && (t == m_done);
    ref_decode(alu_op, func, c, ill, md, hl);
    e_stall = in_valid && !flush && in_busy && (md || hl);
    if (m_ready) begin
      check("out_valid", out_valid, e_ov);
      check("alu_ctrl",  alu_ctrl,  e_ctrl);
      check("illegal",   illegal,   e_ill);
      check("md_start",  md_start,  e_start);
      check("md_op",     md_op,     m_op);
      check("md_busy",   md_busy,   in_busy || in_done);
      check("hilo_we",   hilo_we,   in_done);
      check("stall",     stall,     e_stall);
    end
    n_start += int'(md_start === 1'b1);
    n_hilo  += int'(hilo_we === 1'b1);
    acc = in_valid && !flush && !e_stall;
    if (rst) begin
      m_ready = 1'b1; m_active = 1'b0; m_op = 2'b00;
      e_ov = 1'b0; e_ctrl = 4'b0010; e_ill = 1'b0; e_start = 1'b0;
    end else begin
      e_ov = acc;
      if (acc) begin
        e_ctrl = c; e_ill = ill;
      end
      e_start = acc && md;
      if (acc && md) begin
        lat      = func[1] ? DIV_LAT : MUL_LAT;
        m_active = 1'b1;
        m_op     = func[1:0];
        m_done   = t + ((lat < 2) ? 2 : lat);
      end else if (in_done) begin
        m_active = 1'b0;
      end
    end
    t++;
  end

  logic s_stall, s_hilo;

  task automatic drive(input logic v, input logic [2:0] op, input logic [5:0] f,
                       input logic fl, input logic r);
    in_valid = v; alu_op = op; func = f; flush = fl; rst = r;
    #2;
    s_stall = stall;
    s_hilo  = hilo_we;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 3'd0, 6'd0, 1'b0, 1'b0);
  endtask

  logic [5:0] rf [10] = '{6'b100000, 6'b100001, 6'b100010, 6'b100011, 6'b100100,
                          6'b100101, 6'b100110, 6'b100111, 6'b101010, 6'b101011};
  logic [3:0] rc [10] = '{4'b0010, 4'b0010, 4'b0110, 4'b0110, 4'b0000,
                          4'b0001, 4'b0011, 4'b1100, 4'b0111, 4'b0101};
  logic [2:0] io [6]  = '{3'd0, 3'd1, 3'd3, 3'd4, 3'd5, 3'd6};
  logic [3:0] ic [6]  = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b0111, 4'b0101};

  initial begin : stim
    int k, stalls, h0, st0;
    logic [5:0] f;
    logic [2:0] op;
    rst = 1'b1; in_valid = 1'b0; alu_op = '0; func = '0; flush = 1'b0;
    for (int i = 0; i < 3; i++) drive(1'b0, 3'd0, 6'd0, 1'b0, 1'b1);
    idle(1);
    check("rst out_valid", out_valid, 1'b0);
    check("rst alu_ctrl",  alu_ctrl,  4'b0010);
    check("rst illegal",   illegal,   1'b0);
    check("rst md_busy",   md_busy,   1'b0);
    check("rst md_op",     md_op,     2'b00);
    check("rst hilo_we",   hilo_we,   1'b0);

    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 3'd2, rf[i], 1'b0, 1'b0);
      check("rtype valid",   out_valid, 1'b1);
      check("rtype ctrl",    alu_ctrl,  rc[i]);
      check("rtype illegal", illegal,   1'b0);
    end
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, io[i], 6'b111111, 1'b0, 1'b0);
      check("class ctrl", alu_ctrl, ic[i]);
    end

    drive(1'b1, 3'd2, 6'b111111, 1'b0, 1'b0);
    check("bad funct ctrl", alu_ctrl, 4'b0010);
    check("bad funct ill",  illegal,  1'b1);
    drive(1'b1, 3'd0, 6'd0, 1'b0, 1'b0);
    check("add clears ill", illegal, 1'b0);
    drive(1'b1, 3'd7, 6'd0, 1'b0, 1'b0);
    check("op7 illegal", illegal, 1'b1);
    drive(1'b1, 3'd3, 6'd0, 1'b0, 1'b0);
    drive(1'b0, 3'd1, 6'd0, 1'b0, 1'b0);
    check("bubble valid", out_valid, 1'b0);
    check("bubble hold",  alu_ctrl,  4'b0000);
    drive(1'b1, 3'd2, 6'b010000, 1'b0, 1'b0);
    check("mfhi idle ill", illegal, 1'b0);

    // mult: start in t1, HI/LO write in t4, busy t1..t4
    drive(1'b1, 3'd2, 6'b011000, 1'b0, 1'b0);
    for (int j = 1; j <= 6; j++) begin
      check("mult start", md_start, j == 1);
      check("mult hilo",  hilo_we,  j == 4);
      check("mult busy",  md_busy,  j <= 4);
      idle(1);
    end

    // div then mflo: stalled until the DONE cycle, an add slips through in BUSY
    drive(1'b1, 3'd2, 6'b011010, 1'b0, 1'b0);
    drive(1'b1, 3'd2, 6'b010010, 1'b0, 1'b0);
    stalls = int'(s_stall);
    check("mflo t1 stall", s_stall, 1'b1);
    drive(1'b1, 3'd0, 6'd0, 1'b0, 1'b0);
    check("add t2 stall", s_stall, 1'b0);
    check("add t2 accepted", out_valid, 1'b1);
    k = 3;
    while (k < 60) begin
      drive(1'b1, 3'd2, 6'b010010, 1'b0, 1'b0);
      if (!s_stall) break;
      stalls++;
      k++;
    end
    check("mflo accept cycle", k, 32);
    check("mflo stall count",  stalls, 30);
    check("hilo at accept",    s_hilo, 1'b1);
    check("mflo out_valid",    out_valid, 1'b1);
    idle(2);

    // flush a dependent mult while the first is in flight
    st0 = n_start; h0 = n_hilo;
    drive(1'b1, 3'd2, 6'b011001, 1'b0, 1'b0);
    drive(1'b1, 3'd2, 6'b011000, 1'b1, 1'b0);
    check("flush no stall", s_stall, 1'b0);
    idle(8);
    check("flush one start", n_start - st0, 1);
    check("flush one hilo",  n_hilo - h0,   1);

    // reset while the div counter sits at 2
    drive(1'b1, 3'd2, 6'b011011, 1'b0, 1'b0);
    idle(29);
    drive(1'b0, 3'd0, 6'd0, 1'b0, 1'b1);
    check("rst busy",  md_busy, 1'b0);
    check("rst md_op", md_op,   2'b00);
    h0 = n_hilo;
    idle(40);
    check("rst no hilo", n_hilo - h0, 0);
    drive(1'b1, 3'd2, 6'b011001, 1'b0, 1'b0);
    check("restart start", md_start, 1'b1);
    check("restart op",    md_op,    2'b01);
    idle(6);

    for (int i = 0; i < 3000; i++) begin
      k = int'($urandom_range(15, 0));
      if (k < 4)       f = {4'b0110, 2'($urandom_range(3, 0))};
      else if (k < 6)  f = (k == 4) ? 6'b010000 : 6'b010010;
      else if (k < 14) f = rf[$urandom_range(9, 0)];
      else             f = 6'($urandom_range(63, 0));
      op = ($urandom_range(1, 0) == 1) ? 3'd2 : 3'($urandom_range(7, 0));
      drive($urandom_range(3, 0) != 0, op, f, $urandom_range(9, 0) == 0,
            $urandom_range(199, 0) == 0);
    end
    idle(4);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
